// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcode constants, ALU operation enum and
// writeback-select codes used by the execute-stage control logic.
package rv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    // alt selects SUB/SRA; the caller decides which funct3 values may honour it.
    function automatic alu_op_e funct3_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Purely combinational RV32I ALU: result = f(a, b) as chosen by alusel.
// Shift amounts come from b[4:0]; arithmetic wraps.
module exec_alu
    import rv_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  alu_op_e           alusel,
    output logic [DWIDTH-1:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    // NOTE: result gets a value on every path (default arm) so no latch is inferred.
    always_comb begin
        case (alusel)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << shamt;
            ALU_SLT:   result = {{(DWIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  result = {{(DWIDTH-1){1'b0}}, (a < b)};
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_PASSB: result = b;
            default:   result = a + b;
        endcase
    end

endmodule

// File: rtl/exec_ctrl_unit.sv
// Execute-stage block: instruction decode, branch comparator, operand muxes
// and ALU, with every output registered once.
module exec_ctrl_unit
    import rv_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       insn_i,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] rs1data_i,
    input  logic [DWIDTH-1:0] rs2data_i,
    input  logic [DWIDTH-1:0] imm_i,
    output logic [DWIDTH-1:0] res_o,
    output logic              brtaken_o,
    output logic              breq_o,
    output logic              brlt_o,
    output logic              regwren_o,
    output logic              memren_o,
    output logic              memwren_o,
    output logic [1:0]        wbsel_o,
    output logic [3:0]        alusel_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       unused_insn_bits;

    assign opcode           = insn_i[6:0];
    assign funct3           = insn_i[14:12];
    assign alt              = insn_i[30];
    assign unused_insn_bits = ^{insn_i[31], insn_i[29:15], insn_i[11:7]};

    alu_op_e    alu_op;
    logic       use_pc, use_rs2, is_branch, is_jump, clr_lsb;
    logic       regwren, memren, memwren;
    logic [1:0] wbsel;

    always_comb begin
        alu_op    = ALU_ADD;
        use_pc    = 1'b0;
        use_rs2   = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        clr_lsb   = 1'b0;
        regwren   = 1'b0;
        memren    = 1'b0;
        memwren   = 1'b0;
        wbsel     = WB_ALU;
        case (opcode)
            OPC_OP:     begin use_rs2 = 1'b1; regwren = 1'b1; alu_op = funct3_op(funct3, alt); end
            OPC_OPIMM:  begin regwren = 1'b1; alu_op = funct3_op(funct3, alt && (funct3 == 3'b101)); end
            OPC_LUI:    begin regwren = 1'b1; alu_op = ALU_PASSB; end
            OPC_AUIPC:  begin regwren = 1'b1; use_pc = 1'b1; end
            OPC_JAL:    begin regwren = 1'b1; use_pc = 1'b1; is_jump = 1'b1; wbsel = WB_PC4; end
            OPC_JALR:   begin regwren = 1'b1; is_jump = 1'b1; clr_lsb = 1'b1; wbsel = WB_PC4; end
            OPC_BRANCH: begin use_pc = 1'b1; is_branch = 1'b1; end
            OPC_LOAD:   begin regwren = 1'b1; memren = 1'b1; wbsel = WB_LOAD; end
            OPC_STORE:  memwren = 1'b1;
            default:    ;
        endcase
    end

    // funct3[1] distinguishes the unsigned branch forms (BLTU/BGEU).
    logic eq, lt, cond;
    assign eq = (rs1data_i == rs2data_i);
    assign lt = funct3[1] ? (rs1data_i < rs2data_i)
                          : ($signed(rs1data_i) < $signed(rs2data_i));

    always_comb begin
        case (funct3)
            3'b000:         cond = eq;
            3'b001:         cond = ~eq;
            3'b100, 3'b110: cond = lt;
            3'b101, 3'b111: cond = ~lt;
            default:        cond = 1'b0;
        endcase
    end

    logic [DWIDTH-1:0] op_a, op_b, alu_res, res_d;
    assign op_a  = use_pc ? DWIDTH'(pc_i) : rs1data_i;
    assign op_b  = use_rs2 ? rs2data_i : imm_i;
    assign res_d = clr_lsb ? {alu_res[DWIDTH-1:1], 1'b0} : alu_res;

    exec_alu #(.DWIDTH(DWIDTH)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .alusel (alu_op),
        .result (alu_res)
    );

    // NOTE: reset is sampled only on the clock edge, and state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!reset) begin
            res_o     <= '0;
            brtaken_o <= 1'b0;
            breq_o    <= 1'b0;
            brlt_o    <= 1'b0;
            regwren_o <= 1'b0;
            memren_o  <= 1'b0;
            memwren_o <= 1'b0;
            wbsel_o   <= 2'b00;
            alusel_o  <= 4'd0;
        end else begin
            res_o     <= res_d;
            brtaken_o <= is_jump | (is_branch & cond);
            breq_o    <= is_branch & eq;
            brlt_o    <= is_branch & lt;
            regwren_o <= regwren;
            memren_o  <= memren;
            memwren_o <= memwren;
            wbsel_o   <= wbsel;
            alusel_o  <= alu_op;
        end
    end

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Self-checking bench for exec_ctrl_unit: reset sequence, directed vector
// table, then randomized instructions against a behavioural model.
module tb_exec_ctrl_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] insn, pc, rs1, rs2, imm;
    logic [31:0] res;
    logic        brtaken, breq, brlt, regwren, memren, memwren;
    logic [1:0]  wbsel;
    logic [3:0]  alusel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exec_ctrl_unit #(.DWIDTH(32), .AWIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .insn_i    (insn),
        .pc_i      (pc),
        .rs1data_i (rs1),
        .rs2data_i (rs2),
        .imm_i     (imm),
        .res_o     (res),
        .brtaken_o (brtaken),
        .breq_o    (breq),
        .brlt_o    (brlt),
        .regwren_o (regwren),
        .memren_o  (memren),
        .memwren_o (memwren),
        .wbsel_o   (wbsel),
        .alusel_o  (alusel)
    );

    typedef struct {
        logic [31:0] insn, pc, rs1, rs2, imm;
        logic [31:0] res;
        logic        bt, eq, lt, rw, mr, mw;
        logic [1:0]  wb;
        logic [3:0]  alu;
    } vec_t;

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        return {f7, 10'd0, f3, 5'd0, op};
    endfunction

    function automatic vec_t vec(input logic [31:0] i, p, a, b, im, r,
                                 input logic bt, eq, lt, rw, mr, mw,
                                 input logic [1:0] wb, input logic [3:0] alu);
        vec_t v;
        v.insn = i; v.pc = p; v.rs1 = a; v.rs2 = b; v.imm = im; v.res = r;
        v.bt = bt; v.eq = eq; v.lt = lt; v.rw = rw; v.mr = mr; v.mw = mw;
        v.wb = wb; v.alu = alu;
        return v;
    endfunction

    // Reference ALU for register/immediate arithmetic, by funct3 meaning.
    function automatic void arith(input logic [2:0] f3, input logic alt, input logic [31:0] x, y,
                                  output logic [3:0] sel, output logic [31:0] r);
        int sh;
        sh = int'(y % 32);
        case (f3)
            3'd0: begin sel = alt ? 4'd1 : 4'd0; r = alt ? x - y : x + y; end
            3'd1: begin sel = 4'd2; r = x << sh; end
            3'd2: begin sel = 4'd3; r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0; end
            3'd3: begin sel = 4'd4; r = (x < y) ? 32'd1 : 32'd0; end
            3'd4: begin sel = 4'd5; r = x ^ y; end
            3'd5: begin sel = alt ? 4'd7 : 4'd6; r = alt ? $unsigned($signed(x) >>> sh) : x >> sh; end
            3'd6: begin sel = 4'd8; r = x | y; end
            default: begin sel = 4'd9; r = x & y; end
        endcase
    endfunction

    function automatic vec_t model(input logic [31:0] i, p, a, b, im);
        vec_t v;
        logic [2:0] f3;
        logic lt_s, lt_u;
        f3 = i[14:12];
        v = vec(i, p, a, b, im, a + im, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
        lt_s = $signed(a) < $signed(b);
        lt_u = a < b;
        case (i[6:0])
            7'h33: begin v.rw = 1; arith(f3, i[30], a, b, v.alu, v.res); end
            7'h13: begin v.rw = 1; arith(f3, i[30] && f3 == 3'd5, a, im, v.alu, v.res); end
            7'h37: begin v.rw = 1; v.alu = 4'd10; v.res = im; end
            7'h17: begin v.rw = 1; v.res = p + im; end
            7'h6F: begin v.rw = 1; v.wb = 2'd2; v.bt = 1; v.res = p + im; end
            7'h67: begin v.rw = 1; v.wb = 2'd2; v.bt = 1; v.res = (a + im) & 32'hFFFF_FFFE; end
            7'h63: begin
                v.res = p + im;
                v.eq  = (a == b);
                v.lt  = (f3 inside {3'd2, 3'd3, 3'd6, 3'd7}) ? lt_u : lt_s;
                case (f3)
                    3'd0: v.bt = v.eq;
                    3'd1: v.bt = !v.eq;
                    3'd4, 3'd6: v.bt = v.lt;
                    3'd5, 3'd7: v.bt = !v.lt;
                    default: v.bt = 0;
                endcase
            end
            7'h03: begin v.rw = 1; v.mr = 1; v.wb = 2'd1; end
            7'h23: v.mw = 1;
            default: ;
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        check({tag, ".res"},     res,             e.res);
        check({tag, ".brtaken"}, 32'(brtaken),    32'(e.bt));
        check({tag, ".breq"},    32'(breq),       32'(e.eq));
        check({tag, ".brlt"},    32'(brlt),       32'(e.lt));
        check({tag, ".regwren"}, 32'(regwren),    32'(e.rw));
        check({tag, ".memren"},  32'(memren),     32'(e.mr));
        check({tag, ".memwren"}, 32'(memwren),    32'(e.mw));
        check({tag, ".wbsel"},   32'(wbsel),      32'(e.wb));
        check({tag, ".alusel"},  32'(alusel),     32'(e.alu));
    endtask

    // Drive on the falling edge, sample 1 time unit after the capturing edge.
    task automatic step(input vec_t v);
        @(negedge clk);
        insn = v.insn; pc = v.pc; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[25];
    vec_t zero_v, add_v, rv, ev;

    initial begin
        vecs[0]  = vec(enc(7'h33,3'd0,7'h00), 0, 5, 7, 0,                      32'd12,        0,0,0, 1,0,0, 2'd0, 4'd0);
        vecs[1]  = vec(enc(7'h33,3'd0,7'h20), 0, 3, 5, 0,                      32'hFFFFFFFE,  0,0,0, 1,0,0, 2'd0, 4'd1);
        vecs[2]  = vec(enc(7'h13,3'd5,7'h20), 0, 32'h80000000, 0, 32'h404,     32'hF8000000,  0,0,0, 1,0,0, 2'd0, 4'd7);
        vecs[3]  = vec(enc(7'h33,3'd2,7'h00), 0, 32'hFFFFFFFF, 1, 0,           32'd1,         0,0,0, 1,0,0, 2'd0, 4'd3);
        vecs[4]  = vec(enc(7'h33,3'd3,7'h00), 0, 32'hFFFFFFFF, 1, 0,           32'd0,         0,0,0, 1,0,0, 2'd0, 4'd4);
        vecs[5]  = vec(enc(7'h63,3'd4,7'h00), 32'h01000010, 32'hFFFFFFFF, 1, 8, 32'h01000018, 1,0,1, 0,0,0, 2'd0, 4'd0);
        vecs[6]  = vec(enc(7'h63,3'd6,7'h00), 32'h01000010, 32'hFFFFFFFF, 1, 8, 32'h01000018, 0,0,0, 0,0,0, 2'd0, 4'd0);
        vecs[7]  = vec(enc(7'h63,3'd0,7'h00), 32'h100, 32'h1234, 32'h1234, 32'h20, 32'h120,   1,1,0, 0,0,0, 2'd0, 4'd0);
        vecs[8]  = vec(enc(7'h67,3'd0,7'h00), 32'h200, 32'h01000005, 0, 2,     32'h01000006,  1,0,0, 1,0,0, 2'd2, 4'd0);
        vecs[9]  = vec(enc(7'h03,3'd2,7'h00), 0, 32'h01000000, 0, 4,           32'h01000004,  0,0,0, 1,1,0, 2'd1, 4'd0);
        vecs[10] = vec(enc(7'h23,3'd2,7'h00), 0, 32'h01000000, 32'hDEAD, 8,    32'h01000008,  0,0,0, 0,0,1, 2'd0, 4'd0);
        vecs[11] = vec(enc(7'h37,3'd0,7'h00), 0, 32'h55, 0, 32'h12345000,      32'h12345000,  0,0,0, 1,0,0, 2'd0, 4'd10);
        vecs[12] = vec(enc(7'h7F,3'd0,7'h00), 0, 3, 3, 4,                      32'd7,         0,0,0, 0,0,0, 2'd0, 4'd0);
        vecs[13] = vec(enc(7'h6F,3'd0,7'h00), 32'h1000, 32'h999, 0, 32'h40,    32'h1040,      1,0,0, 1,0,0, 2'd2, 4'd0);
        vecs[14] = vec(enc(7'h17,3'd0,7'h00), 32'h2000, 0, 0, 32'h3000,        32'h5000,      0,0,0, 1,0,0, 2'd0, 4'd0);
        vecs[15] = vec(enc(7'h63,3'd1,7'h00), 32'h10, 6, 5, 32'h10,            32'h20,        1,0,0, 0,0,0, 2'd0, 4'd0);
        vecs[16] = vec(enc(7'h63,3'd7,7'h00), 32'h40, 1, 32'hFFFFFFFF, 32'hFFFFFFF0, 32'h30,  0,0,1, 0,0,0, 2'd0, 4'd0);
        vecs[17] = vec(enc(7'h63,3'd2,7'h00), 0, 9, 9, 4,                      32'd4,         0,1,0, 0,0,0, 2'd0, 4'd0);
        vecs[18] = vec(enc(7'h33,3'd5,7'h00), 0, 32'hF0000000, 32'h24, 0,      32'h0F000000,  0,0,0, 1,0,0, 2'd0, 4'd6);
        vecs[19] = vec(enc(7'h33,3'd5,7'h20), 0, 32'hF0000000, 32'h24, 0,      32'hFF000000,  0,0,0, 1,0,0, 2'd0, 4'd7);
        vecs[20] = vec(enc(7'h13,3'd0,7'h7F), 0, 10, 0, 32'hFFFFFFFF,          32'd9,         0,0,0, 1,0,0, 2'd0, 4'd0);
        vecs[21] = vec(enc(7'h33,3'd4,7'h00), 0, 32'hF0F0, 32'hFF00, 0,        32'h0FF0,      0,0,0, 1,0,0, 2'd0, 4'd5);
        vecs[22] = vec(enc(7'h33,3'd6,7'h20), 0, 32'hF0F0, 32'hFF00, 0,        32'hFFF0,      0,0,0, 1,0,0, 2'd0, 4'd8);
        vecs[23] = vec(enc(7'h33,3'd7,7'h00), 0, 32'hF0F0, 32'hFF00, 0,        32'hF000,      0,0,0, 1,0,0, 2'd0, 4'd9);
        vecs[24] = vec(enc(7'h33,3'd1,7'h00), 0, 1, 32'h21, 0,                 32'd2,         0,0,0, 1,0,0, 2'd0, 4'd2);

        zero_v = vec(0, 0, 0, 0, 0, 0, 0,0,0, 0,0,0, 2'd0, 4'd0);
        add_v  = vecs[0];

        // Load non-zero state, then hold reset low for two edges with ADD applied.
        insn = 0; pc = 0; rs1 = 0; rs2 = 0; imm = 0;
        step(vecs[1]);
        @(negedge clk) reset = 1'b0;
        step(add_v);
        check_outputs("reset_cyc1", zero_v);
        step(add_v);
        check_outputs("reset_cyc2", zero_v);
        @(negedge clk) reset = 1'b1;
        step(add_v);
        check_outputs("post_reset_add", add_v);

        for (int i = 0; i < 25; i++)
            begin
                step(vecs[i]);
                check_outputs($sformatf("vec%0d", i), vecs[i]);
            end

        // Back-to-back issue: each cycle's output reflects only that cycle's inputs.
        step(vecs[8]);
        step(vecs[12]);
        check_outputs("b2b_unknown_after_jalr", vecs[12]);

        for (int n = 0; n < 300; n++) begin
            logic [6:0] ops[11];
            logic [31:0] i_w, a, b;
            ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h7F, 7'h00};
            i_w = $urandom;
            i_w[6:0] = (n % 8 == 7) ? 7'($urandom) : ops[$urandom_range(0, 9)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 40);
            rv = model(i_w, $urandom, a, b, $urandom);
            step(rv);
            ev = rv;
            check_outputs($sformatf("rand%0d_op%h", n, i_w[6:0]), ev);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
